// File: rtl/cpu_types_pkg.sv
// Shared CPU types: branch-predictor direction counter and BTB entry layout.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bpred_ctr_t;

    localparam bpred_ctr_t BTB_CTR_RESET = WNT;

    // The tag holds the full word address pc[31:2]; the index bits inside it
    // always equal the entry's own index, so a full compare equals a tag compare.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        bpred_ctr_t  ctr;
    } btb_entry_t;

endpackage

// File: rtl/branch_target_buffer_if.sv
// Bundle of BTB signals: fetch-side lookup and MEM-side update/redirect.
interface branch_target_buffer_if;
    logic [31:0] pc_IF;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        update_en;
    logic [31:0] pc_MEM;
    logic        taken_MEM;
    logic [31:0] target_MEM;
    logic        pred_taken_MEM;
    logic [31:0] pred_target_MEM;
    logic        clear;
    logic        mispredict;
    logic [31:0] redirect_pc;

    modport fetch (output pc_IF, input pred_taken, pred_target);
    modport mem (output update_en, pc_MEM, taken_MEM, target_MEM, pred_taken_MEM,
                 pred_target_MEM, clear, input mispredict, redirect_pc);
endinterface

// File: rtl/sat_counter2.sv
// 2-bit saturating direction counter next-state: up on taken, down otherwise.
module sat_counter2
    import cpu_types_pkg::*;
(
    input  bpred_ctr_t i_ctr,
    input  logic       i_taken,
    output bpred_ctr_t o_ctr_next
);
    always_comb begin
        o_ctr_next = i_ctr;
        if (i_taken) begin
            if (i_ctr != ST) o_ctr_next = bpred_ctr_t'(i_ctr + 2'd1);
        end else begin
            if (i_ctr != SNT) o_ctr_next = bpred_ctr_t'(i_ctr - 2'd1);
        end
    end
endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational lookup for IF, registered update and
// combinational mispredict/redirect for MEM.
module branch_target_buffer
    import cpu_types_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] pc_IF,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        update_en,
    input  logic [31:0] pc_MEM,
    input  logic        taken_MEM,
    input  logic [31:0] target_MEM,
    input  logic        pred_taken_MEM,
    input  logic [31:0] pred_target_MEM,
    input  logic        clear,
    output logic        mispredict,
    output logic [31:0] redirect_pc
);
    btb_entry_t       w_tab [ENTRIES];
    logic [IDX_W-1:0] w_lk_idx;
    btb_entry_t       w_lk_ent;
    logic             w_lk_hit;
    logic [IDX_W-1:0] w_upd_idx;
    btb_entry_t       w_upd_ent;
    logic             w_upd_hit;
    logic             w_wr_en;
    bpred_ctr_t       w_ctr_next;
    btb_entry_t       w_entry_next;
    logic             w_unused;

    // Byte-offset bits never participate in indexing or tagging.
    assign w_unused = ^{pc_IF[1:0], pc_MEM[1:0]};

    assign w_lk_idx    = pc_IF[IDX_W+1:2];
    assign w_lk_ent    = w_tab[w_lk_idx];
    assign w_lk_hit    = w_lk_ent.valid && (w_lk_ent.tag == pc_IF[31:2]);
    assign pred_taken  = w_lk_hit && w_lk_ent.ctr[1];
    assign pred_target = pred_taken ? w_lk_ent.target : pc_IF + 32'd4;

    assign w_upd_idx = pc_MEM[IDX_W+1:2];
    assign w_upd_ent = w_tab[w_upd_idx];
    assign w_upd_hit = w_upd_ent.valid && (w_upd_ent.tag == pc_MEM[31:2]);
    assign w_wr_en   = update_en && (w_upd_hit || taken_MEM);

    sat_counter2 u_sat_counter2 (
        .i_ctr      (w_upd_ent.ctr),
        .i_taken    (taken_MEM),
        .o_ctr_next (w_ctr_next)
    );

    always_comb begin
        w_entry_next = w_upd_ent;
        if (w_upd_hit) begin
            w_entry_next.ctr = w_ctr_next;
            if (taken_MEM) w_entry_next.target = target_MEM;
        end else begin
            w_entry_next.valid  = 1'b1;
            w_entry_next.tag    = pc_MEM[31:2];
            w_entry_next.target = target_MEM;
            w_entry_next.ctr    = WT;
        end
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            btb_entry_t r_entry;
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    r_entry <= '{valid: 1'b0, tag: '0, target: '0, ctr: BTB_CTR_RESET};
                end else if (clear) begin
                    r_entry.valid <= 1'b0;
                    r_entry.ctr   <= BTB_CTR_RESET;
                end else if (w_wr_en && (w_upd_idx == IDX_W'(gi))) begin
                    r_entry <= w_entry_next;
                end
            end
            assign w_tab[gi] = r_entry;
        end
    endgenerate

    assign mispredict  = update_en && ((taken_MEM != pred_taken_MEM) ||
                                       (taken_MEM && (target_MEM != pred_target_MEM)));
    assign redirect_pc = taken_MEM ? target_MEM : pc_MEM + 32'd4;
endmodule
